// File: rtl/fifo_param_if.sv
// fifo_param_if: bundles the FIFO's producer/consumer signals.
//
// Handshake semantics (one place, applies to every user of this bundle):
//   write/read are requests, sampled on the rising clock edge. A write is
//   taken when write=1 and the FIFO is not full, or a read is taken on the
//   same edge. A read is taken when read=1 and the FIFO is not empty; a
//   same-cycle write never makes an empty read legal. Rejected requests have
//   no effect other than raising the sticky overflow/underflow flag.
//   clear=1 flushes synchronously and overrides read/write on that edge.
//
// Modports:
//   master - the producer/consumer side: drives clear, write, read, data_in,
//            and observes data_out, count and the status flags.
//   slave  - the FIFO itself.
interface fifo_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             clear;
    logic             write;
    logic             read;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, write, read, data_in,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clear, write, read, data_in,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty flags and sticky error flags.
//
// Ports:
//   clock - system clock, all state updates on the rising edge.
//   reset - asynchronous active-low reset, release synchronous to clock.
//   bus   - fifo_param_if.slave: clear, write, read, data_in in;
//           data_out, full, empty, almost_full, almost_empty, count,
//           overflow, underflow out.
//
// Parameters: WIDTH (>=1), DEPTH (power of two, >=2),
//   AF_THRESH (almost_full when count >= AF_THRESH, must be <= DEPTH),
//   AE_THRESH (almost_empty when count <= AE_THRESH, must be < DEPTH).
//
// Build option: define FIFO_FWFT_EN for first-word-fall-through output,
// where data_out continuously shows the head word. Without it data_out is a
// register loaded by each accepted read (one cycle latency).
module fifo_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic        clock,
    input  logic        reset,
    fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count_r;
    logic             overflow_r;
    logic             underflow_r;

    logic full_w;
    logic empty_w;
    logic rd_ok;
    logic wr_ok;

    // Flags are pure decodes of the registered count, so they move on the
    // same edge as count does.
    assign full_w  = (count_r == DEPTH_C);
    assign empty_w = (count_r == '0);

    // clear wins over both requests, so neither is accepted on a clear edge.
    assign rd_ok = bus.read & ~empty_w & ~bus.clear;
    assign wr_ok = bus.write & (~full_w | rd_ok) & ~bus.clear;

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_r >= AF_C);
    assign bus.almost_empty = (count_r <= AE_C);
    assign bus.count        = count_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

    // Storage is not reset; contents are don't-care after reset or clear
    // because count gates every observable read.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wptr] <= bus.data_in;
        end
    end

    // Pointers and occupancy. Pointers are AW bits wide so they wrap from
    // DEPTH-1 to 0 with no extra logic.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count_r <= '0;
        end else if (bus.clear) begin
            wptr    <= '0;
            rptr    <= '0;
            count_r <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags: only a write that is actually dropped sets
    // overflow (a full write paired with an accepted read is legal).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (bus.clear) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (bus.write && full_w && !rd_ok) begin
                overflow_r <= 1'b1;
            end
            if (bus.read && empty_w) begin
                underflow_r <= 1'b1;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word shown directly; forced to zero while empty so the output is
    // defined after reset even though storage is not.
    assign bus.data_out = empty_w ? '0 : mem[rptr];
`else
    logic [WIDTH-1:0] data_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_r <= '0;
        end else if (bus.clear) begin
            data_r <= '0;
        end else if (rd_ok) begin
            data_r <= mem[rptr];
        end
    end

    assign bus.data_out = data_r;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: self-checking bench for fifo_param (WIDTH=32, DEPTH=8,
// AF_THRESH=6, AE_THRESH=1). The reference is a plain queue of words plus
// the sticky flags; every expected output is derived from the queue size.
module tb_fifo_param;
    localparam int W  = 32;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 1;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

    fifo_param #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_THRESH(AF),
        .AE_THRESH(AE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_dout;
    logic         exp_ovf;
    logic         exp_unf;
    int           checks   = 0;
    int           failures = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    // One clock edge of the reference, using the pre-edge occupancy.
    task automatic model_step(input logic wr, input logic rd, input logic clr,
                              input logic [W-1:0] din);
        bit rd_ok;
        bit wr_ok;
        if (clr) begin
            model_reset();
        end else begin
            rd_ok = rd && (exp_q.size() > 0);
            wr_ok = wr && ((exp_q.size() < D) || rd_ok);
            if (wr && exp_q.size() == D && !rd_ok) exp_ovf = 1'b1;
            if (rd && exp_q.size() == 0) exp_unf = 1'b1;
            if (rd_ok) exp_dout = exp_q.pop_front();
            if (wr_ok) exp_q.push_back(din);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [W-1:0] want_dout;
        n = exp_q.size();
`ifdef FIFO_FWFT_EN
        want_dout = (n > 0) ? exp_q[0] : '0;
`else
        want_dout = exp_dout;
`endif
        check({tag, ".count"},        64'(bus.count),        64'(n));
        check({tag, ".empty"},        64'(bus.empty),        64'(n == 0));
        check({tag, ".full"},         64'(bus.full),         64'(n == D));
        check({tag, ".almost_full"},  64'(bus.almost_full),  64'(n >= AF));
        check({tag, ".almost_empty"}, 64'(bus.almost_empty), 64'(n <= AE));
        check({tag, ".overflow"},     64'(bus.overflow),     64'(exp_ovf));
        check({tag, ".underflow"},    64'(bus.underflow),    64'(exp_unf));
        check({tag, ".data_out"},     64'(bus.data_out),     64'(want_dout));
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input string tag, input logic wr, input logic rd,
                               input logic clr, input logic [W-1:0] din);
        bus.write   = wr;
        bus.read    = rd;
        bus.clear   = clr;
        bus.data_in = din;
        @(posedge clock);
        model_step(wr, rd, clr, din);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.clear   = 1'b0;
        bus.data_in = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] vals3 [3];
        int bias_w;
        int bias_r;

        vals3[0] = 32'd100;
        vals3[1] = 32'd150;
        vals3[2] = 32'd200;

        // Reset held low with write requested: nothing may be accepted.
        idle_inputs();
        reset       = 1'b0;
        bus.write   = 1'b1;
        bus.data_in = 32'hDEAD_BEEF;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all("rst");
        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_all("post_rst");

        // Three words in, three out, in order.
        for (int i = 0; i < 3; i++) drive_cycle("wr3", 1'b1, 1'b0, 1'b0, vals3[i]);
        for (int i = 0; i < 3; i++) drive_cycle("rd3", 1'b0, 1'b1, 1'b0, '0);

        // Nine writes into eight entries, then drain.
        for (int i = 0; i < 9; i++) drive_cycle("fill9", 1'b1, 1'b0, 1'b0, 32'h1000 + i);
        for (int i = 0; i < 8; i++) drive_cycle("drain8", 1'b0, 1'b1, 1'b0, '0);

        // Read while empty (also with a write alongside), then clear.
        drive_cycle("rd_empty", 1'b0, 1'b1, 1'b0, '0);
        drive_cycle("rd_empty_wr", 1'b1, 1'b1, 1'b0, 32'h55);
        drive_cycle("clear", 1'b1, 1'b1, 1'b1, 32'h77);

        // Fill, then simultaneous write+read long enough to wrap pointers.
        for (int i = 0; i < 8; i++) drive_cycle("fill", 1'b1, 1'b0, 1'b0, 32'h2000 + i);
        for (int i = 0; i < 11; i++) drive_cycle("wr_rd_full", 1'b1, 1'b1, 1'b0, 32'h3000 + i);
        for (int i = 0; i < 8; i++) drive_cycle("drain", 1'b0, 1'b1, 1'b0, '0);

        // Threshold walk: six writes then six reads; flags checked each edge.
        for (int i = 0; i < 6; i++) drive_cycle("af_up", 1'b1, 1'b0, 1'b0, 32'h4000 + i);
        for (int i = 0; i < 6; i++) drive_cycle("af_dn", 1'b0, 1'b1, 1'b0, '0);

        // Randomised phases with varying read/write bias and rare clears.
        for (int ph = 0; ph < 12; ph++) begin
            bias_w = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            bias_r = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 80 : 50;
            for (int c = 0; c < 150; c++) begin
                drive_cycle("rand",
                            $urandom_range(0, 99) < bias_w,
                            $urandom_range(0, 99) < bias_r,
                            $urandom_range(0, 63) == 0,
                            $urandom);
            end
            // Once, pull reset mid-stream and check the async clear before
            // the next edge.
            if (ph == 5) begin
                bus.write = 1'b1;
                bus.read  = 1'b1;
                reset     = 1'b0;
                #1;
                model_reset();
                check_all("async_rst");
                @(posedge clock);
                #1;
                check_all("async_rst_hold");
                reset = 1'b1;
                idle_inputs();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's 32-bit fixed FIFO.
- Adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags.
- Optional first-word-fall-through (FWFT) output mode.
- Sits between producer and consumer blocks in the same clock domain.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 8, number of entries; must be a power of two, >=2.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately, release synchronous to clock.
- clear  input  1  synchronous flush; active-high.
- write  input  1  write request.
- read  input  1  read request.
- data_in  input  WIDTH  write data.
- data_out  output  WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0 (see FWFT).
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: write rejected while full.
- underflow  output  1  sticky: read rejected while empty.

Behaviour:
- Reset values (reset low, asynchronous):
  - Pointers = 0, count = 0, data_out = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = (AF_THRESH == 0).
  - overflow = 0, underflow = 0.
- Storage and pointers:
  - Storage is DEPTH x WIDTH registers.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write acceptance:
  - wr_ok = write & (!full | rd_ok).
  - A write while full is accepted only if a read is accepted in the same cycle.
- Read acceptance:
  - rd_ok = read & !empty.
  - A read while empty is rejected even if a write occurs in the same cycle.
- Accepted write: mem[wptr] <= data_in; wptr increments.
- Accepted read (standard mode): data_out <= mem[rptr] on the same edge; rptr increments. Read latency is 1 cycle from read-high edge to data valid.
- data_out holds its value when no read is accepted.
- count update per edge: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- All flags derive from registered count and change on the same edge as count.
- overflow: set on write & full & !rd_ok.
- underflow: set on read & empty.
- Both error flags hold until reset or clear.
- Rejected operations never modify storage, pointers or count.
- clear (synchronous, priority over read/write in the same cycle):
  - Pointers = 0, count = 0, data_out = 0.
  - overflow and underflow cleared.
  - Storage contents are don't-care.
- Reset asserted mid-operation aborts everything immediately; the first cycle after release behaves as after power-up.
- Undefined configurations: AF_THRESH > DEPTH or AE_THRESH >= DEPTH is a configuration error; behaviour is undefined and the bench must not use it.

Optional Feature:
- FIFO_FWFT_EN defined (first-word-fall-through):
  - data_out continuously presents mem[rptr], the head word.
  - empty = (count == 0) still; when empty is low, data_out is valid without a read.
  - A word written into an empty FIFO appears on data_out 1 cycle after the write edge.
  - An accepted read pops the head; the next word appears on the same edge.
  - clear leaves data_out as don't-care while empty.
- FIFO_FWFT_EN undefined: standard registered-read behaviour described above.

Test Plan:
- Reset low with write=1 -> count=0, empty=1, full=0, data_out=0; no write accepted.
- Write 100, 150, 200 (DEPTH=8), then read 3 -> data_out sequence 100, 150, 200, each 1 cycle after its read edge; count 3->0; empty=1 at end.
- Write 9 words into DEPTH=8 -> full=1 after 8th; 9th rejected; overflow=1; count=8; then drain 8 -> data in order, no corruption.
- Read when empty -> underflow=1, count stays 0; then clear=1 for 1 cycle -> underflow=0, overflow=0.
- Fill to full, then write+read in the same cycle -> both accepted; count stays 8; pointers wrap past DEPTH-1 with data order preserved.
- AF_THRESH=6, AE_THRESH=1: write 6 -> almost_full rises on the 6th write edge; almost_empty falls on the 2nd. With FIFO_FWFT_EN, first written value is visible on data_out 1 cycle after the write and before any read.
